pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the 16-bit CPU family. Owns the PC and issues
//  requests to instruction memory over a req/ack handshake. Buffers fetched words, tagged with
//  their PC, in a small FIFO and hands them to decode/execute over a valid/ready interface.
//  Redirects the PC on taken branch or jump, flushing stale fetches.
// PARAMETERS
//  ADDR_W     16   PC / instruction address width
//  INSTR_W    16   instruction word width
//  OFFSET_W   8    signed branch offset width (instruction-word units)
//  PC_STEP    2    sequential PC increment (bytes)
//  RESET_PC   11   PC value after reset
//  BUF_DEPTH  2    fetch FIFO entries (power of 2, >=2)
// PORTS
//  Clock          in   1         system clock, rising edge
//  Resetn         in   1         reset, asynchronous, active-low
//  imem_req       out  1         fetch request; held until imem_ack
//  imem_addr      out  ADDR_W    fetch address; stable while imem_req=1
//  imem_ack       in   1         memory accepted request, imem_rdata valid this cycle
//  imem_rdata     in   INSTR_W   fetched instruction
//  instr_valid    out  1         head of FIFO valid
//  instr          out  INSTR_W   head instruction
//  instr_pc       out  ADDR_W    PC of head instruction
//  instr_ready    in   1         consumer takes head this edge (if instr_valid)
//  br_taken       in   1         branch resolved taken
//  br_pc          in   ADDR_W    PC of the branch instruction
//  br_offset      in   OFFSET_W  signed word offset
//  jmp_valid      in   1         jump redirect
//  jmp_target     in   ADDR_W    absolute jump target
// BEHAVIOUR
//  Reset (async, Resetn=0): imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0,
//   FIFO empty, FSM=RUN. First imem_req=1 is driven in the first cycle after Resetn rises.
//  FSM states:
//   RUN   no request outstanding. If FIFO not full (count incl. pending push < BUF_DEPTH),
//         assert imem_req with imem_addr=fetch_pc and go to WAIT.
//   WAIT  imem_req=1, addr held. On imem_ack: push {fetch_pc, imem_rdata};
//         fetch_pc += PC_STEP. Continue with back-to-back req if space remains (stay WAIT),
//         else go to RUN with req=0.
//   DROP  a redirect hit while a request was outstanding without ack. Keep req/addr until
//         imem_ack, discard the data, then go to RUN with fetch_pc = latched target.
//  ack may arrive in the same cycle req rises (zero-wait memory); the data is captured on that
//   edge.
//  Redirect target:
//   jump: jmp_target.
//   branch: br_pc + PC_STEP + (sext(br_offset) << 1).
//   All arithmetic modulo 2^ADDR_W (wrap).
//  Priority: jmp_valid over br_taken when both are asserted.
//  On redirect edge: FIFO flushed (instr_valid=0 next cycle); instr_ready ignored that cycle.
//   An ack in the same cycle is discarded. fetch_pc=target. State -> DROP if req outstanding
//   without ack, else RUN.
//  A redirect while in DROP replaces the latched target.
//  FIFO: push and pop in the same cycle are allowed when full; count is unchanged.
//   Pop requires instr_valid & instr_ready.
//   Outputs are registered from the FIFO head; latency from ack to instr_valid is 1 cycle.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds ports perf_fetched out 32 (pushes into FIFO) and
//   perf_flushes out 16 (redirects). Both saturate and reset to 0.
//  FETCH_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package cpu16_pkg: FSM state encoding (RUN/WAIT/DROP) and FIFO entry layout
//   {pc, instr}.
//  Sub-module fetch_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with flush, push,
//   pop, full, empty.
//  FSM and PC/target logic live in pc_fetch_unit.
// TESTING
//  1 Reset release, ack 1 cycle after req, instr_ready=1
//    -> imem_addr 11,13,15...; instr_pc 11,13,15 in order.
//  2 instr_ready=0, BUF_DEPTH=2 -> exactly 2 acks accepted, imem_req=0 afterwards;
//    ready=1 resumes fetch at 15.
//  3 br_taken, br_pc=13, br_offset=-2 -> FIFO flushed, next imem_addr=11.
//  4 Redirect with req outstanding, ack 3 cycles later -> state DROP; stale word never
//    valid; then fetch at target.
//  5 jmp_valid (target 0x0040) and br_taken same cycle -> next fetch 0x0040.
//  6 jmp_target=0xFFFF -> fetches 0xFFFF then 0x0001 (wrap);
//    with FETCH_PERF_EN, perf_flushes=1.

Source files
------------

// File: rtl/cpu16_pkg.sv
// cpu16_pkg: fetch FSM state encoding and fetch FIFO entry layout shared by the fetch front end
package cpu16_pkg;
    localparam int CPU_ADDR_W  = 16;
    localparam int CPU_INSTR_W = 16;
    typedef enum logic [1:0] {RUN, WAIT, DROP} fetch_state_t;
    // FIFO entries are packed {pc, instr}, pc in the upper bits
    typedef struct packed {
        logic [CPU_ADDR_W-1:0]  pc;
        logic [CPU_INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; head is read straight from the storage registers
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    // storage is cleared on reset so the head outputs read zero until the first push
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner and imem req/ack fetcher feeding a tagged instruction FIFO with redirect flush
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_flushes counters.
module pc_fetch_unit import cpu16_pkg::*; #(
    parameter int ADDR_W    = CPU_ADDR_W,
    parameter int INSTR_W   = CPU_INSTR_W,
    parameter int OFFSET_W  = 8,
    parameter int PC_STEP   = 2,
    parameter int RESET_PC  = 11,
    parameter int BUF_DEPTH = 2
) (
    input  logic                Clock,
    input  logic                Resetn,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_pc,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic                jmp_valid,
    input  logic [ADDR_W-1:0]   jmp_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [15:0]         perf_flushes
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int EW = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc, next_pc, target;
    logic              redirect, push, pop, full, empty;
    logic [CW-1:0]     count, next_count;
    logic [EW-1:0]     head;
    assign redirect   = jmp_valid | br_taken;
    assign target     = jmp_valid ? jmp_target
                                  : br_pc + STEP + (ADDR_W'($signed(br_offset)) << 1);
    assign push       = (state == WAIT) & imem_ack & ~redirect;
    assign pop        = instr_valid & instr_ready & ~redirect;
    assign next_count = count + CW'(push) - CW'(pop);
    assign next_pc    = fetch_pc + STEP;
    assign instr_valid = ~empty;
    assign instr       = head[INSTR_W-1:0];
    assign instr_pc    = head[EW-1:INSTR_W];
    fetch_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_fifo (
        .Clock (Clock),
        .Resetn(Resetn),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .din   ({fetch_pc, imem_rdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // a redirect with the request still un-acked must keep the bus stable until the stale ack
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= RUN;
            imem_req  <= 1'b0;
            imem_addr <= ADDR_W'(RESET_PC);
            fetch_pc  <= ADDR_W'(RESET_PC);
        end else if (redirect) begin
            fetch_pc <= target;
            if (imem_req && !imem_ack) begin
                state <= DROP;
            end else begin
                state    <= RUN;
                imem_req <= 1'b0;
            end
        end else begin
            case (state)
                RUN: if (!full) begin
                    state     <= WAIT;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end
                WAIT: if (imem_ack) begin
                    fetch_pc <= next_pc;
                    if (next_count < CW'(BUF_DEPTH)) begin
                        imem_addr <= next_pc;
                    end else begin
                        state    <= RUN;
                        imem_req <= 1'b0;
                    end
                end
                DROP: if (imem_ack) begin
                    state    <= RUN;
                    imem_req <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (push && ~&perf_fetched) perf_fetched <= perf_fetched + 32'd1;
            if (redirect && ~&perf_flushes) perf_flushes <= perf_flushes + 16'd1;
        end
    end
`endif
endmodule
